// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - frame-buffer / test-pattern pixel pipeline with VS lock and sync realignment
module vga_pixel_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic        VGA_CLK,
    input  logic        RST,
    input  logic        PIXEL,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic [18:0] P_COUNT,
    input  logic [1:0]  PATTERN_SEL,
    input  logic [11:0] MEM_RDATA,
    output logic [18:0] MEM_ADDR,
    output logic        MEM_RD,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS_O,
    output logic        VGA_VS_O,
    output logic        FRAME_START
);
    localparam int L = RD_LAT + 2;
    // Depth at which pixel-side side-band lines up with MEM_RDATA.
    localparam int D = L - 1;

    typedef enum logic [1:0] {
        WAIT_VS  = 2'd0,
        WAIT_END = 2'd1,
        RUN      = 2'd2
    } lock_state_e;

    lock_state_e state_q, state_d;

    logic        vs_prev_q;
    logic        pix_prev_q;
    logic [9:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic [1:0]  sel_q, sel_d;
    logic [18:0] mem_addr_q;
    logic        mem_rd_q;
    logic [11:0] rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d;

    logic [L-1:0]  hs_pipe_q;
    logic [L-1:0]  vs_pipe_q;
    logic [D-1:0]  pix_pipe_q;
    logic [D-1:0]  lock_pipe_q;
    logic [D-1:0]  mem_pipe_q;
    logic [11:0]   pat_pipe_q [D];

    logic        vs_fall;
    logic        vs_rise;
    logic        timing_err;
    logic        lock_now;
    logic        use_mem;
    logic [2:0]  bar_idx;
    logic [11:0] pat_rgb;
    logic        row_unused;

    assign vs_fall    = vs_prev_q & ~VGA_VS;
    assign vs_rise    = ~vs_prev_q & VGA_VS;
    assign timing_err = PIXEL & ~VGA_VS;
    // The corrupting pixel itself is already treated as unlocked.
    assign lock_now   = (state_q == RUN) && !timing_err;
    assign use_mem    = (sel_q == 2'd0);
    assign row_unused = ^{row_q[8:6], row_q[4:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_VS:  if (vs_fall) state_d = WAIT_END;
            WAIT_END: if (vs_rise) state_d = RUN;
            RUN:      if (timing_err) state_d = WAIT_VS;
            default:  state_d = WAIT_VS;
        endcase
    end

    always_comb begin
        col_d = PIXEL ? (col_q + 10'd1) : 10'd0;
        row_d = row_q;
        if (vs_fall) begin
            row_d = 9'd0;
        end else if (pix_prev_q && !PIXEL) begin
            row_d = row_q + 9'd1;
        end
        sel_d = vs_fall ? PATTERN_SEL : sel_q;
    end

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (col_q >= 10'(80 * k)) bar_idx = 3'(k);
        end
        case (sel_q)
            2'd1:    pat_rgb = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
            2'd2:    pat_rgb = {12{col_q[5] ^ row_q[5]}};
            2'd3:    pat_rgb = 12'hFFF;
            default: pat_rgb = 12'h000;
        endcase
    end

    always_comb begin
        rgb_d = 12'h000;
        if (pix_pipe_q[D-1] && lock_pipe_q[D-1]) begin
            rgb_d = mem_pipe_q[D-1] ? MEM_RDATA : pat_pipe_q[D-1];
        end
        frame_start_d = vs_pipe_q[L-1] & ~vs_pipe_q[L-2] & lock_pipe_q[D-1];
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            state_q       <= WAIT_VS;
            vs_prev_q     <= 1'b0;
            pix_prev_q    <= 1'b0;
            col_q         <= 10'd0;
            row_q         <= 9'd0;
            sel_q         <= 2'd0;
            mem_addr_q    <= 19'd0;
            mem_rd_q      <= 1'b0;
            rgb_q         <= 12'h000;
            frame_start_q <= 1'b0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            pix_pipe_q    <= '0;
            lock_pipe_q   <= '0;
            mem_pipe_q    <= '0;
            for (int i = 0; i < D; i++) pat_pipe_q[i] <= 12'h000;
        end else begin
            state_q       <= state_d;
            vs_prev_q     <= VGA_VS;
            pix_prev_q    <= PIXEL;
            col_q         <= col_d;
            row_q         <= row_d;
            sel_q         <= sel_d;
            mem_addr_q    <= P_COUNT;
            mem_rd_q      <= PIXEL;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            hs_pipe_q     <= {hs_pipe_q[L-2:0], VGA_HS};
            vs_pipe_q     <= {vs_pipe_q[L-2:0], VGA_VS};
            pix_pipe_q    <= {pix_pipe_q[D-2:0], PIXEL};
            lock_pipe_q   <= {lock_pipe_q[D-2:0], lock_now};
            mem_pipe_q    <= {mem_pipe_q[D-2:0], use_mem};
            pat_pipe_q[0] <= pat_rgb;
            for (int i = 1; i < D; i++) pat_pipe_q[i] <= pat_pipe_q[i-1];
        end
    end

    assign MEM_ADDR    = mem_addr_q;
    assign MEM_RD      = mem_rd_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign VGA_HS_O    = hs_pipe_q[L-1];
    assign VGA_VS_O    = vs_pipe_q[L-1];
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb/tb_vga_pixel_pipe.sv - directed bench for vga_pixel_pipe at RD_LAT=2 and RD_LAT=4
module tb_vga_pixel_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        pixel;
    logic        hs;
    logic        vs;
    logic [18:0] p_count;
    logic [1:0]  psel;
    logic [11:0] rdata2, rdata4;
    logic [18:0] addr2, addr4;
    logic        rd2, rd4;
    logic [3:0]  r2, g2, b2, r4, g4, b4;
    logic        hso2, vso2, hso4, vso4, fs2, fs4;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;

    logic hist_pix [8];
    logic hist_hs  [8];
    logic hist_vs  [8];
    logic hist_blk [8];
    int   hist_row [8];
    int   hist_col [8];

    int          w_row [16];
    int          w_col [16];
    logic [11:0] w_exp [16];
    bit          w_hit2 [16];
    bit          w_hit4 [16];
    int          nw = 0;

    int n_fs2 = 0;
    int n_fs4 = 0;
    int hs4_run = 0;
    int hs4_width = 0;

    always #5 clk = ~clk;

    vga_pixel_pipe #(.RD_LAT(2)) dut2 (
        .VGA_CLK(clk), .RST(rst), .PIXEL(pixel), .VGA_HS(hs), .VGA_VS(vs),
        .P_COUNT(p_count), .PATTERN_SEL(psel), .MEM_RDATA(rdata2),
        .MEM_ADDR(addr2), .MEM_RD(rd2), .VGA_R(r2), .VGA_G(g2), .VGA_B(b2),
        .VGA_HS_O(hso2), .VGA_VS_O(vso2), .FRAME_START(fs2)
    );

    vga_pixel_pipe #(.RD_LAT(4)) dut4 (
        .VGA_CLK(clk), .RST(rst), .PIXEL(pixel), .VGA_HS(hs), .VGA_VS(vs),
        .P_COUNT(p_count), .PATTERN_SEL(psel), .MEM_RDATA(rdata4),
        .MEM_ADDR(addr4), .MEM_RD(rd4), .VGA_R(r4), .VGA_G(g4), .VGA_B(b4),
        .VGA_HS_O(hso4), .VGA_VS_O(vso4), .FRAME_START(fs4)
    );

    // Frame buffer returns addr[11:0] after a fixed latency.
    logic [11:0] mem2_q [2];
    logic [11:0] mem4_q [4];
    always @(posedge clk) begin
        mem2_q[0] <= addr2[11:0];
        mem2_q[1] <= mem2_q[0];
        mem4_q[0] <= addr4[11:0];
        for (int i = 1; i < 4; i++) mem4_q[i] <= mem4_q[i-1];
    end
    assign rdata2 = mem2_q[1];
    assign rdata4 = mem4_q[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic add_watch(input int row, input int col, input logic [11:0] exp);
        w_row[nw] = row;
        w_col[nw] = col;
        w_exp[nw] = exp;
        w_hit2[nw] = 1'b0;
        w_hit4[nw] = 1'b0;
        nw++;
    endtask

    task automatic check_out(input int lat, input logic [11:0] rgb, input logic hso,
                             input logic vso, input string who, input bit is4);
        int i;
        i = (ncyc - lat + 8) % 8;
        chk($sformatf("hs_o_%s", who), 32'(hso), 32'(hist_hs[i]));
        chk($sformatf("vs_o_%s", who), 32'(vso), 32'(hist_vs[i]));
        if (!hist_pix[i] || hist_blk[i]) begin
            chk($sformatf("blank_%s", who), 32'(rgb), 32'd0);
        end else begin
            for (int w = 0; w < nw; w++) begin
                if (hist_row[i] == w_row[w] && hist_col[i] == w_col[w]) begin
                    chk($sformatf("pix_%s_r%0d_c%0d", who, w_row[w], w_col[w]),
                        32'(rgb), 32'(w_exp[w]));
                    if (is4) w_hit4[w] = 1'b1;
                    else     w_hit2[w] = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input logic p, input logic h, input logic v, input int row,
                       input int col, input logic r, input logic blk);
        int k;
        k = ncyc % 8;
        rst     = r;
        pixel   = p;
        hs      = h;
        vs      = v;
        p_count = p ? 19'(640 * row + col) : 19'd0;
        hist_pix[k] = p;
        hist_hs[k]  = h;
        hist_vs[k]  = v;
        hist_blk[k] = blk;
        hist_row[k] = row;
        hist_col[k] = col;
        if (r) begin
            for (int j = 0; j < 8; j++) begin
                hist_pix[j] = 1'b0;
                hist_hs[j]  = 1'b1;
                hist_vs[j]  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
        check_out(4, {r2, g2, b2}, hso2, vso2, "d2", 1'b0);
        check_out(6, {r4, g4, b4}, hso4, vso4, "d4", 1'b1);
        if (fs2) n_fs2++;
        if (fs4) n_fs4++;
        if (!hso4) begin
            hs4_run++;
        end else if (hs4_run != 0) begin
            hs4_width = hs4_run;
            hs4_run = 0;
        end
    endtask

    // nrows active lines, then front porch, VS line, back porch.
    task automatic frame(input int nrows, input int ncols, input logic blk, input int sel_row,
                         input logic [1:0] new_sel, input logic corrupt, input int rst_row);
        logic b, v, h, a, rs;
        b = blk;
        for (int r = 0; r < nrows + 3; r++) begin
            v = (r != nrows + 1);
            if (r == sel_row) psel = new_sel;
            for (int c = 0; c < ncols + 104; c++) begin
                a  = (r < nrows) && (c < ncols);
                h  = !((c >= ncols + 4) && (c < ncols + 100));
                rs = (r == rst_row) && (c == 100);
                if (corrupt && r == nrows + 1 && c == 10) begin
                    a = 1'b1;
                    b = 1'b1;
                end
                cyc(a, h, v, r, c, rs, b);
                if (rs) begin
                    b = 1'b1;
                    chk("rst_next_rgb", 32'({r2, g2, b2}), 32'd0);
                    chk("rst_next_hs_o", 32'(hso2), 32'd1);
                    chk("rst_next_vs_o", 32'(vso2), 32'd1);
                end
            end
        end
    endtask

    task automatic end_frame(input string name, input int exp_fs);
        chk($sformatf("%s_frame_start_d2", name), 32'(n_fs2), 32'(exp_fs));
        chk($sformatf("%s_frame_start_d4", name), 32'(n_fs4), 32'(exp_fs));
        for (int w = 0; w < nw; w++) begin
            chk($sformatf("%s_seen_d2_r%0d_c%0d", name, w_row[w], w_col[w]), 32'(w_hit2[w]), 32'd1);
            chk($sformatf("%s_seen_d4_r%0d_c%0d", name, w_row[w], w_col[w]), 32'(w_hit4[w]), 32'd1);
        end
        n_fs2 = 0;
        n_fs4 = 0;
        nw = 0;
    endtask

    initial begin
        psel = 2'd0;
        for (int j = 0; j < 8; j++) begin
            hist_pix[j] = 1'b0;
            hist_hs[j]  = 1'b1;
            hist_vs[j]  = 1'b1;
            hist_blk[j] = 1'b0;
            hist_row[j] = 0;
            hist_col[j] = 0;
        end
        for (int j = 0; j < 4; j++) cyc(1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0);

        chk("rst_addr_d2", 32'(addr2), 32'd0);
        chk("rst_rd_d2", 32'(rd2), 32'd0);
        chk("rst_rgb_d2", 32'({r2, g2, b2}), 32'd0);
        chk("rst_fs_d2", 32'(fs2), 32'd0);
        chk("rst_addr_d4", 32'(addr4), 32'd0);
        chk("rst_rd_d4", 32'(rd4), 32'd0);
        chk("rst_rgb_d4", 32'({r4, g4, b4}), 32'd0);
        chk("rst_fs_d4", 32'(fs4), 32'd0);
        n_fs2 = 0;
        n_fs4 = 0;

        // Frame 1: not yet locked, all black.
        frame(2, 640, 1'b1, -1, 2'd0, 1'b0, -1);
        end_frame("f1", 0);

        // Frame 2: memory; bars requested mid-frame must not apply yet.
        add_watch(0, 0, 12'h000);
        add_watch(0, 100, 12'h064);
        add_watch(1, 5, 12'h285);
        add_watch(1, 639, 12'h4FF);
        frame(2, 640, 1'b0, 1, 2'd1, 1'b0, -1);
        end_frame("f2", 1);
        chk("hs_o_low_width_d4", 32'(hs4_width), 32'd96);

        // Frame 3: colour bars; checkerboard requested mid-frame.
        add_watch(0, 0, 12'h000);
        add_watch(0, 79, 12'h000);
        add_watch(0, 80, 12'h00F);
        add_watch(0, 160, 12'h0F0);
        add_watch(0, 559, 12'hFF0);
        add_watch(0, 560, 12'hFFF);
        add_watch(0, 639, 12'hFFF);
        add_watch(1, 80, 12'h00F);
        frame(2, 640, 1'b0, 1, 2'd2, 1'b0, -1);
        end_frame("f3", 1);

        // Frame 4: checkerboard over 33 short lines; solid white next.
        add_watch(0, 31, 12'h000);
        add_watch(0, 32, 12'hFFF);
        add_watch(1, 0, 12'h000);
        add_watch(31, 63, 12'hFFF);
        add_watch(32, 0, 12'hFFF);
        add_watch(32, 32, 12'h000);
        frame(33, 64, 1'b0, 0, 2'd3, 1'b0, -1);
        end_frame("f4", 1);

        // Frame 5: white, then PIXEL forced high inside the VS line.
        add_watch(0, 0, 12'hFFF);
        add_watch(0, 639, 12'hFFF);
        frame(1, 640, 1'b0, -1, 2'd3, 1'b1, -1);
        end_frame("f5", 1);

        // Frame 6: relocking, black and no frame start.
        frame(1, 640, 1'b1, -1, 2'd3, 1'b0, -1);
        end_frame("f6", 0);

        // Frame 7: locked again; memory selected for later frames.
        add_watch(0, 7, 12'hFFF);
        frame(1, 640, 1'b0, 0, 2'd0, 1'b0, -1);
        end_frame("f7", 1);

        // Frame 8: reset pulse mid-line.
        add_watch(0, 50, 12'h032);
        frame(1, 640, 1'b0, -1, 2'd0, 1'b0, 0);
        end_frame("f8", 0);

        // Frame 9: relocked after the reset frame's VS pulse.
        add_watch(0, 3, 12'h003);
        add_watch(0, 300, 12'h12C);
        frame(1, 640, 1'b0, -1, 2'd0, 1'b0, -1);
        end_frame("f9", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_pixel_pipe.md
VGA_PIXEL_PIPE -- requirements
Module: vga_pixel_pipe

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning frame-buffer read latency in cycles (MEM_ADDR to MEM_RDATA), legal range 1..4.
REQ-002 SHALL have port VGA_CLK  in  1  pixel clock; the only clock.
REQ-003 SHALL have port RST  in  1  reset; synchronous to VGA_CLK, active-high.
REQ-004 SHALL have port PIXEL  in  1  active-video flag from timing generator.
REQ-005 SHALL have port VGA_HS  in  1  horizontal sync from timing generator, active-low.
REQ-006 SHALL have port VGA_VS  in  1  vertical sync from timing generator, active-low.
REQ-007 SHALL have port P_COUNT  in  19  linear pixel index (640*row+col) from timing generator.
REQ-008 SHALL have port PATTERN_SEL  in  2  source: 0 memory, 1 colour bars, 2 checkerboard, 3 solid white.
REQ-009 SHALL have port MEM_RDATA  in  12  frame-buffer read data {R[3:0],G[3:0],B[3:0]}.
REQ-010 SHALL have port MEM_ADDR  out  19  frame-buffer read address.
REQ-011 SHALL have port MEM_RD  out  1  read strobe, qualifies MEM_ADDR.
REQ-012 SHALL have port VGA_R / VGA_G / VGA_B  out  4 each  pixel colour to DAC.
REQ-013 SHALL have port VGA_HS_O / VGA_VS_O  out  1 each  syncs delayed to align with colour.
REQ-014 SHALL have port FRAME_START  out  1  one-cycle pulse at each VGA_VS_O falling edge while locked.

Function
REQ-015 Stage 1 SHALL register P_COUNT into MEM_ADDR and PIXEL into MEM_RD every cycle (MEM_RD=1 only for active pixels).
REQ-016 MEM_RDATA SHALL be treated as valid exactly RD_LAT cycles after the MEM_ADDR it answers; no handshake, no stall.
REQ-017 Colour outputs SHALL be registered one cycle after MEM_RDATA capture; total latency input->VGA_R/G/B SHALL be L = RD_LAT+2 cycles.
REQ-018 PIXEL, VGA_HS, VGA_VS SHALL pass through an L-stage shift register; VGA_HS_O/VGA_VS_O SHALL equal inputs delayed exactly L cycles in all states.
REQ-019 Internal COL (10 bit) SHALL increment on each active PIXEL cycle and clear on the first cycle PIXEL=0; ROW (9 bit) SHALL increment on PIXEL 1->0 and clear on VGA_VS 1->0.
REQ-020 COL/ROW-derived pattern colour SHALL be delayed to emerge on the same cycle as the memory colour for that pixel.
REQ-021 Bars: index = COL/80 (0..7, saturate at 7); R=index[2]?F:0, G=index[1]?F:0, B=index[0]?F:0.
REQ-022 Checkerboard: white (FFF) when COL[5]^ROW[5]=1, else black.
REQ-023 PATTERN_SEL SHALL be sampled into an internal register only on input VGA_VS 1->0 and after reset; mid-frame changes SHALL not affect the current frame.
REQ-024 Lock FSM states: WAIT_VS (after reset), WAIT_END, RUN.
REQ-025 WAIT_VS -> WAIT_END on input VGA_VS 1->0; WAIT_END -> RUN on input VGA_VS 0->1; RUN -> WAIT_VS if PIXEL=1 while VGA_VS=0 (timing corruption).
REQ-026 VGA_R/G/B SHALL be 0 whenever delayed PIXEL=0 or FSM is not RUN at the cycle the pixel entered stage 1 (lock flag delayed with the pixel).
REQ-027 FRAME_START SHALL pulse high one cycle when VGA_VS_O goes 1->0 and the lock flag aligned with it is RUN; never otherwise.
REQ-028 Simultaneous RUN->WAIT_VS and VS edge: the error transition SHALL take priority.

Reset
REQ-029 On RST=1 at a clock edge: FSM=WAIT_VS, MEM_ADDR=0, MEM_RD=0, VGA_R/G/B=0, FRAME_START=0, COL=0, ROW=0, pattern register=0.
REQ-030 Reset SHALL fill the sync delay line with 1 (inactive) and PIXEL/lock delay lines with 0, so VGA_HS_O=VGA_VS_O=1 for at least L cycles after reset release.
REQ-031 Reset asserted mid-frame SHALL blank colour on the next cycle and require a full WAIT_VS->WAIT_END->RUN sequence before non-zero colour.

Verification
REQ-032 Reset, drive 640x480@800x525 timing, PATTERN_SEL=0, memory returns addr[11:0] after 2 cycles -> first frame all black; second frame pixel (row 1, col 5) outputs 0x285 exactly 4 cycles after P_COUNT=645.
REQ-033 Same stimulus, RD_LAT=4 -> colour and VGA_HS_O edges both appear 6 cycles after input; HS_O low pulse width 96 cycles.
REQ-034 PATTERN_SEL=1 set mid-frame -> current frame unchanged; next frame col 0..79 = 000, col 80 = 00F, col 560..639 = FFF.
REQ-035 PATTERN_SEL=2 -> (row 0, col 31)=000, (row 0, col 32)=FFF, (row 32, col 32)=000; blanking intervals = 000.
REQ-036 Force PIXEL=1 during VGA_VS=0 -> FSM to WAIT_VS, colour 0 until next full VS pulse completes, no FRAME_START in between.
REQ-037 Assert RST for 1 cycle mid-line -> next-cycle VGA_R/G/B=0, VGA_HS_O=VGA_VS_O=1 for L cycles, FRAME_START only after re-lock.
